fp_nr_div: RTL and testbench



---
 rtl/fp_wire.sv | 50 +++++
 rtl/fp_rcp_seed.sv | 16 +
 rtl/fp_nr_div.sv | 167 ++++++++++++++++
 tb/tb_fp_nr_div.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_wire.sv
// Shared types and constants for the FP divide path: mac operand/result bundles,
// divider request/response bundles, sequencer state encoding and Q2.54 helpers.
package fp_wire;

  localparam logic [55:0] FP_NR_ONE = 56'h40000000000000;

  typedef struct packed {
    logic [55:0] a;
    logic [55:0] b;
    logic [55:0] c;
    logic        op;
  } fp_mac_in_type;

  typedef struct packed {
    logic [109:0] d;
  } fp_mac_out_type;

  typedef struct packed {
    logic        start;
    logic [52:0] n_mant;
    logic [52:0] d_mant;
  } fp_nr_div_in_type;

  typedef struct packed {
    logic        ready;
    logic        valid;
    logic [55:0] q;
    logic        rem_nz;
    logic        err;
  } fp_nr_div_out_type;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    UPD,
    MULQ,
    REM,
    DONE
  } fp_nr_div_state_type;

  // Mac result is scaled by 2^108; keep the top 56 bits (floor).
  function automatic logic [55:0] nr_narrow(input logic [109:0] d);
    return d[109:54];
  endfunction

  function automatic logic [55:0] nr_extend(input logic [52:0] m);
    return {1'b0, m, 2'b00};
  endfunction

endpackage

// File: rtl/fp_rcp_seed.sv
// Reciprocal seed ROM: seed = round(65536 / (128 + idx + 0.5)), 257..510.
module fp_rcp_seed (
  input  logic [6:0] idx,
  output logic [8:0] seed
);

  logic [8:0] w_rom [128];

  // Odd denominators 257+2i never give an exact half, so floor(x + 1/2) is exact rounding.
  for (genvar gi = 0; gi < 128; gi++) begin : g_rom
    assign w_rom[gi] = 9'((262144 + 257 + 2 * gi) / (514 + 4 * gi));
  end

  assign seed = w_rom[idx];

endmodule

// File: rtl/fp_nr_div.sv
// Newton-Raphson mantissa divide sequencer; issues one d = (a<<54) +/- b*c per cycle
// to a downstream combinational mac and returns a truncated Q2.54 quotient.
//
// state | meaning
// IDLE  | waiting for start, ready high
// ERR   | e = 1 - D*y
// UPD   | y = y + y*e, counts one refinement
// MULQ  | q = N*y
// REM   | r = N - D*q, step q toward floor until 0 <= r < D
// DONE  | one-cycle valid strobe
module fp_nr_div
  import fp_wire::*;
#(
  parameter int ITER     = 3,
  parameter int MAX_CORR = 3
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [52:0]    n_mant,
  input  logic [52:0]    d_mant,
  output logic           ready,
  output logic           valid,
  output logic [55:0]    q,
  output logic           rem_nz,
  output logic           err,
  output fp_mac_in_type  mac_o,
  input  fp_mac_out_type mac_i
);

  localparam logic [7:0] ITER_LAST = 8'(ITER - 1);
  localparam logic [7:0] CORR_MAX  = 8'(MAX_CORR);

  fp_nr_div_state_type r_state;
  logic [55:0] r_n;
  logic [55:0] r_d;
  logic [55:0] r_y;
  logic [55:0] r_e;
  logic [55:0] r_q;
  logic [7:0]  r_iter;
  logic [7:0]  r_corr;
  logic        r_ready;
  logic        r_valid;
  logic        r_rem_nz;
  logic        r_err;

  logic [8:0]  w_seed;
  logic [55:0] w_narrow;
  logic        w_r_neg;
  logic        w_r_ge_d;

  fp_rcp_seed u_seed (
    .idx  (d_mant[51:45]),
    .seed (w_seed)
  );

  assign w_narrow = nr_narrow(mac_i.d);
  assign w_r_neg  = mac_i.d[109];
  assign w_r_ge_d = !mac_i.d[109] && (mac_i.d >= {54'd0, r_d});

  // Operands come only from registered state so the mac never sees start/mantissa inputs.
  always_comb begin
    mac_o = '0;
    case (r_state)
      ERR: begin
        mac_o.a  = FP_NR_ONE;
        mac_o.b  = r_d;
        mac_o.c  = r_y;
        mac_o.op = 1'b1;
      end
      UPD: begin
        mac_o.a = r_y;
        mac_o.b = r_y;
        mac_o.c = r_e;
      end
      MULQ: begin
        mac_o.b = r_n;
        mac_o.c = r_y;
      end
      REM: begin
        mac_o.a  = r_n;
        mac_o.b  = r_d;
        mac_o.c  = r_q;
        mac_o.op = 1'b1;
      end
      default: mac_o = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_n      <= '0;
      r_d      <= '0;
      r_y      <= '0;
      r_e      <= '0;
      r_q      <= '0;
      r_iter   <= '0;
      r_corr   <= '0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_rem_nz <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_n      <= nr_extend(n_mant);
            r_d      <= nr_extend(d_mant);
            r_y      <= {2'b00, w_seed, 45'd0};
            r_iter   <= '0;
            r_corr   <= '0;
            r_rem_nz <= 1'b0;
            r_err    <= 1'b0;
            r_ready  <= 1'b0;
            r_state  <= ERR;
          end
        end
        ERR: begin
          r_e     <= w_narrow;
          r_state <= UPD;
        end
        UPD: begin
          r_y     <= w_narrow;
          r_iter  <= r_iter + 8'd1;
          r_state <= (r_iter == ITER_LAST) ? MULQ : ERR;
        end
        MULQ: begin
          r_q     <= w_narrow;
          r_state <= REM;
        end
        REM: begin
          if (w_r_neg || w_r_ge_d) begin
            if (r_corr == CORR_MAX) begin
              r_err   <= 1'b1;
              r_valid <= 1'b1;
              r_state <= DONE;
            end else begin
              r_q    <= w_r_neg ? r_q - 56'd1 : r_q + 56'd1;
              r_corr <= r_corr + 8'd1;
            end
          end else begin
            r_rem_nz <= |mac_i.d;
            r_valid  <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready  = r_ready;
  assign valid  = r_valid;
  assign q      = r_q;
  assign rem_nz = r_rem_nz;
  assign err    = r_err;

endmodule

// File: tb/tb_fp_nr_div.sv
// Bench for fp_nr_div: three instances (ITER=3,2,1) fed identical stimulus, each with a
// behavioural mac and a scoreboard queue checked against an integer division reference.
module tb_fp_nr_div;
  import fp_wire::*;

  typedef struct {
    logic [52:0] n;
    logic [52:0] d;
    logic [55:0] q;
    logic        rem_nz;
    int          start_cyc;
    int          lat_exact;
    bit          no_err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [52:0] n_mant = '0;
  logic [52:0] d_mant = '0;

  logic           w_ready  [3];
  logic           w_valid  [3];
  logic [55:0]    w_q      [3];
  logic           w_rem_nz [3];
  logic           w_err    [3];
  fp_mac_in_type  w_mac_o  [3];
  fp_mac_out_type w_mac_i  [3];

  exp_t sb [3][$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   err_cnt  [3];
  bit   vprev    [3];

  function automatic logic [109:0] mac_f(fp_mac_in_type m);
    logic signed [111:0] a, b, c, p;
    a = {{56{m.a[55]}}, m.a};
    b = {{56{m.b[55]}}, m.b};
    c = {{56{m.c[55]}}, m.c};
    p = b * c;
    a = a <<< 54;
    return m.op ? 110'(a - p) : 110'(a + p);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fp_nr_div #(.ITER(3 - g), .MAX_CORR(3)) u_dut (
      .clock  (clock),
      .reset  (reset),
      .start  (start),
      .n_mant (n_mant),
      .d_mant (d_mant),
      .ready  (w_ready[g]),
      .valid  (w_valid[g]),
      .q      (w_q[g]),
      .rem_nz (w_rem_nz[g]),
      .err    (w_err[g]),
      .mac_o  (w_mac_o[g]),
      .mac_i  (w_mac_i[g])
    );
    assign w_mac_i[g].d = mac_f(w_mac_o[g]);
  end

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_div(logic [52:0] n, logic [52:0] d);
    exp_t e;
    logic [127:0] num, den;
    num = {75'd0, n} << 54;
    den = {75'd0, d};
    e.n = n;
    e.d = d;
    e.q = 56'(num / den);
    e.rem_nz = (num % den) != 0;
    e.start_cyc = 0;
    e.lat_exact = 0;
    e.no_err = 1'b0;
    return e;
  endfunction

  // Result monitor: pops the expectation for each DUT as its valid strobe arrives.
  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (vprev[k]) chk($sformatf("valid_pulse_dut%0d", k), w_valid[k], 1'b0);
      vprev[k] = w_valid[k];
      if (w_valid[k]) begin
        chk($sformatf("unexpected_valid_dut%0d", k), sb[k].size() > 0, 1'b1);
        if (sb[k].size() > 0) begin
          exp_t e;
          int   lat, base;
          e    = sb[k].pop_front();
          lat  = cyc - e.start_cyc + 1;
          base = 2 * (3 - k) + 3;
          if (w_err[k]) err_cnt[k]++;
          if (k == 0 && e.no_err) chk("err_dut0", w_err[k], 1'b0);
          if (!w_err[k]) begin
            chk($sformatf("q_dut%0d n=%h d=%h", k, e.n, e.d), w_q[k], e.q);
            chk($sformatf("rem_nz_dut%0d n=%h d=%h", k, e.n, e.d), w_rem_nz[k], e.rem_nz);
          end
          if (k == 0 && e.lat_exact != 0) chk("latency_exact", lat, e.lat_exact);
          else chk($sformatf("latency_range_dut%0d", k), (lat >= base) && (lat <= base + 3), 1'b1);
        end
      end
    end
  end

  task automatic issue(input logic [52:0] n, input logic [52:0] d, input int lat_exact,
                       input bit no_err);
    exp_t e;
    int t;
    t = 0;
    while (!(w_ready[0] && w_ready[1] && w_ready[2]) && t < 100) begin
      @(negedge clock);
      t++;
    end
    chk("ready_timeout", t < 100, 1'b1);
    n_mant = n;
    d_mant = d;
    start  = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    e = ref_div(n, d);
    e.start_cyc = cyc;
    e.lat_exact = lat_exact;
    e.no_err = no_err;
    for (int k = 0; k < 3; k++) sb[k].push_back(e);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && t < 200) begin
      @(negedge clock);
      t++;
    end
    chk("drain_timeout", t < 200, 1'b1);
  endtask

  task automatic chk_reset_state(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_ready"}, w_ready[k], 1'b1);
      chk({tag, "_valid"}, w_valid[k], 1'b0);
      chk({tag, "_q"}, w_q[k], 56'd0);
      chk({tag, "_rem_nz"}, w_rem_nz[k], 1'b0);
      chk({tag, "_err"}, w_err[k], 1'b0);
      chk({tag, "_mac_o"}, w_mac_o[k], 169'd0);
    end
  endtask

  initial begin
    logic [52:0] rn, rd;
    logic [55:0] y0;
    int seed_ref;
    for (int k = 0; k < 3; k++) begin
      err_cnt[k] = 0;
      vprev[k] = 1'b0;
    end

    repeat (3) @(negedge clock);
    chk_reset_state("reset");
    reset = 1'b0;
    @(negedge clock);

    // n = d = 1.0
    issue(53'h10000000000000, 53'h10000000000000, 0, 1'b1);
    drain();

    // n = 1.0, d = 1.5: exact zero-correction path, probe the mac operands of ERR and UPD
    seed_ref = $rtoi(65536.0 / (128.5 + 64.0) + 0.5);
    y0 = 56'(seed_ref) << 45;
    issue(53'h10000000000000, 53'h18000000000000, 9, 1'b1);
    @(negedge clock);
    chk("mac_err_a", w_mac_o[0].a, FP_NR_ONE);
    chk("mac_err_b", w_mac_o[0].b, 56'h60000000000000);
    chk("mac_err_c", w_mac_o[0].c, y0);
    chk("mac_err_op", w_mac_o[0].op, 1'b1);
    chk("busy_ready", w_ready[0], 1'b0);
    @(negedge clock);
    chk("mac_upd_a", w_mac_o[0].a, y0);
    chk("mac_upd_b", w_mac_o[0].b, y0);
    chk("mac_upd_c", w_mac_o[0].c, 56'h400000000000);
    chk("mac_upd_op", w_mac_o[0].op, 1'b0);
    drain();

    issue(53'h1FFFFFFFFFFFFF, 53'h10000000000000, 0, 1'b1);
    drain();
    issue(53'h10000000000000, 53'h1FFFFFFFFFFFFF, 0, 1'b1);
    drain();
    issue(53'h1FFFFFFFFFFFFF, 53'h1FFFFFFFFFFFFF, 0, 1'b1);
    drain();

    // start while busy must be ignored
    issue(53'h1A5A5A5A5A5A5A, 53'h13C3C3C3C3C3C3, 0, 1'b0);
    repeat (2) @(negedge clock);
    n_mant = 53'h1000000000000F;
    d_mant = 53'h1F000000000000;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 3; k++) chk("busy_start_ready", w_ready[k], 1'b0);
    drain();
    repeat (15) @(negedge clock);

    // reset during UPD aborts without a result
    issue(53'h15555555555555, 53'h12345678123456, 0, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) sb[k].delete();
    @(negedge clock);
    chk_reset_state("abort");
    issue(53'h10000000000000, 53'h18000000000000, 9, 1'b1);
    drain();

    for (int i = 0; i < 2500; i++) begin
      rn = {1'b1, 20'($urandom), 32'($urandom)};
      rd = {1'b1, 20'($urandom), 32'($urandom)};
      if (i % 4 == 1) begin
        rn[51:44] = 8'hFF;
        rd[51:44] = 8'h00;
      end
      issue(rn, rd, 0, 1'b0);
    end
    drain();

    chk("iter1_err_seen", err_cnt[2] > 0, 1'b1);
    $display("info: err results at ITER=3/2/1: %0d %0d %0d", err_cnt[0], err_cnt[1], err_cnt[2]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
